// File: rtl/fifo_pkg.sv
// Shared widths and types for the dual-port-RAM FIFO controller.
package fifo_pkg;

   localparam int unsigned ADDR_W = 8;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned DEPTH  = 2 ** ADDR_W;

   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [DATA_W-1:0] data_t;
   typedef logic [ADDR_W:0]   cnt_t;
   typedef logic [ADDR_W+1:0] lvl_t;

endpackage

// File: rtl/fifo_out_buf.sv
// Two-entry output buffer behind the RAM read port. Entry 0 is the head.
module fifo_out_buf #(
   parameter int unsigned DATA_W = fifo_pkg::DATA_W
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              cap_i,
   input  logic [DATA_W-1:0] cap_data_i,
   input  logic              pop_i,
   output logic              valid_o,
   output logic [DATA_W-1:0] data_o,
   output logic [1:0]        cnt_o
);

   logic [DATA_W-1:0] ent0_q, ent0_d;
   logic [DATA_W-1:0] ent1_q, ent1_d;
   logic [1:0]        cnt_q, cnt_d;

   // Next-state for entries and count; capture with pop shifts the queue.
   always_comb begin
      ent0_d = ent0_q;
      ent1_d = ent1_q;
      cnt_d  = cnt_q;
      case ({cap_i, pop_i})
         2'b10: begin
            if (cnt_q == 2'd0) begin
               ent0_d = cap_data_i;
            end else begin
               ent1_d = cap_data_i;
            end
            cnt_d = cnt_q + 2'd1;
         end
         2'b01: begin
            ent0_d = ent1_q;
            cnt_d  = cnt_q - 2'd1;
         end
         2'b11: begin
            if (cnt_q == 2'd1) begin
               ent0_d = cap_data_i;
            end else begin
               ent0_d = ent1_q;
               ent1_d = cap_data_i;
            end
         end
         default: ;
      endcase
   end

   // Buffer state; entries clear on reset so the head reads zero.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ent0_q <= '0;
         ent1_q <= '0;
         cnt_q  <= '0;
      end else begin
         ent0_q <= ent0_d;
         ent1_q <= ent1_d;
         cnt_q  <= cnt_d;
      end
   end

   // Head presentation.
   always_comb begin
      valid_o = (cnt_q != 2'd0);
      data_o  = ent0_q;
      cnt_o   = cnt_q;
   end

endmodule

// File: rtl/dpram_fifo_ctrl.sv
// FIFO controller driving a 256x8 dual-port RAM: port A writes, port B reads,
// with a two-entry buffer absorbing the RAM's registered read latency.
module dpram_fifo_ctrl #(
   parameter int unsigned ADDR_W    = fifo_pkg::ADDR_W,
   parameter int unsigned DATA_W    = fifo_pkg::DATA_W,
   parameter int unsigned AFULL_LVL = 240
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              in_valid_i,
   input  logic [DATA_W-1:0] in_data_i,
   output logic              in_ready_o,
   output logic              out_valid_o,
   output logic [DATA_W-1:0] out_data_o,
   input  logic              out_ready_i,
   output logic [ADDR_W+1:0] level_o,
   output logic              afull_o,
   output logic              wea_o,
   output logic              rea_o,
   output logic [ADDR_W-1:0] addra_o,
   output logic [DATA_W-1:0] dia_o,
   output logic              web_o,
   output logic              reb_o,
   output logic [ADDR_W-1:0] addrb_o,
   output logic [DATA_W-1:0] dib_o,
   input  logic [DATA_W-1:0] dob_i
);

   localparam int unsigned   Depth   = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] CntFull = (ADDR_W + 1)'(Depth);

   logic [ADDR_W-1:0] wptr_q, wptr_d;
   logic [ADDR_W-1:0] rptr_q, rptr_d;
   logic [ADDR_W:0]   ram_cnt_q, ram_cnt_d;
   logic              rd_pend_q;
   logic              push, pop, rd_issue;
   logic [1:0]        buf_cnt;
   logic [2:0]        occ;

   fifo_out_buf #(
      .DATA_W (DATA_W)
   ) u_out_buf (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .cap_i      (rd_pend_q),
      .cap_data_i (dob_i),
      .pop_i      (pop),
      .valid_o    (out_valid_o),
      .data_o     (out_data_o),
      .cnt_o      (buf_cnt)
   );

   // Handshakes and read issue; a read is issued only if its word is sure to fit.
   always_comb begin
      in_ready_o = (ram_cnt_q != CntFull);
      push       = in_valid_i & in_ready_o;
      pop        = out_valid_o & out_ready_i;
      occ        = {1'b0, buf_cnt} + {2'b00, rd_pend_q} - {2'b00, pop};
      rd_issue   = (ram_cnt_q != '0) && (occ < 3'd2);
   end

   // Pointer and occupancy next-state.
   always_comb begin
      wptr_d    = wptr_q + ADDR_W'(push);
      rptr_d    = rptr_q + ADDR_W'(rd_issue);
      ram_cnt_d = ram_cnt_q;
      case ({push, rd_issue})
         2'b10:   ram_cnt_d = ram_cnt_q + 1'b1;
         2'b01:   ram_cnt_d = ram_cnt_q - 1'b1;
         default: ;
      endcase
   end

   // Controller state; reset drops any read in flight.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wptr_q    <= '0;
         rptr_q    <= '0;
         ram_cnt_q <= '0;
         rd_pend_q <= 1'b0;
      end else begin
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         ram_cnt_q <= ram_cnt_d;
         rd_pend_q <= rd_issue;
      end
   end

   // RAM strobes and occupancy outputs.
   always_comb begin
      wea_o   = push;
      rea_o   = 1'b0;
      addra_o = wptr_q;
      dia_o   = in_data_i;
      web_o   = 1'b0;
      reb_o   = rd_issue;
      addrb_o = rptr_q;
      dib_o   = '0;
      level_o = {1'b0, ram_cnt_q} + (ADDR_W + 2)'(rd_pend_q) + (ADDR_W + 2)'(buf_cnt);
      afull_o = (level_o >= (ADDR_W + 2)'(AFULL_LVL));
   end

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Bench for dpram_fifo_ctrl with a behavioural 256x8 dual-port RAM beside it.
module tb_dpram_fifo_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_ready;
   logic [9:0] level;
   logic       afull;
   logic       wea, rea, web, reb;
   logic [7:0] addra, dia, addrb, dib;
   logic [7:0] dob;

   always #5 clk = ~clk;

   dpram_fifo_ctrl dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .in_valid_i  (in_valid),
      .in_data_i   (in_data),
      .in_ready_o  (in_ready),
      .out_valid_o (out_valid),
      .out_data_o  (out_data),
      .out_ready_i (out_ready),
      .level_o     (level),
      .afull_o     (afull),
      .wea_o       (wea),
      .rea_o       (rea),
      .addra_o     (addra),
      .dia_o       (dia),
      .web_o       (web),
      .reb_o       (reb),
      .addrb_o     (addrb),
      .dib_o       (dib),
      .dob_i       (dob)
   );

   // RAM model: port A write, port B registered read.
   logic [7:0] mem [0:255];
   always @(posedge clk) begin
      if (wea) mem[addra] <= dia;
      if (reb) dob <= mem[addrb];
   end

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
      end
   endtask

   // Scoreboard and observable-port model of the pipeline.
   logic [7:0] exp_q[$];
   int  tb_buf = 0, tb_pend = 0, tb_wptr = 0, tb_rptr = 0;
   int  cyc = 0, first_pop = -1, last_pop = -1, npops = 0, max_level = 0;
   bit  mon_en = 1'b0;

   always @(negedge clk) begin : mon
      int held, ram_m, pop_n;
      bit ir_exp;
      logic [7:0] exp_d;
      cyc++;
      if (mon_en) begin
         held   = exp_q.size();
         ram_m  = held - tb_buf - tb_pend;
         ir_exp = (ram_m != 256);
         pop_n  = (out_valid && out_ready) ? 1 : 0;
         if (int'(level) > max_level) max_level = int'(level);
         check("level", 32'(level), 32'(held));
         check("afull", 32'(afull), 32'(held >= 240));
         check("in_ready", 32'(in_ready), 32'(ir_exp));
         check("out_valid", 32'(out_valid), 32'(tb_buf > 0));
         check("wea", 32'(wea), 32'(in_valid && ir_exp));
         if (wea) check("addra", 32'(addra), 32'(tb_wptr % 256));
         if (reb) begin
            check("addrb", 32'(addrb), 32'(tb_rptr % 256));
            check("reb_room", 32'(((tb_buf + tb_pend - pop_n) < 2) && (ram_m > 0)), 32'd1);
         end
         if (rst) begin
            exp_q.delete();
            tb_buf = 0; tb_pend = 0; tb_wptr = 0; tb_rptr = 0;
         end else begin
            if (pop_n == 1) begin
               if (exp_q.size() == 0) begin
                  check("pop_underflow", 32'd1, 32'd0);
               end else begin
                  exp_d = exp_q.pop_front();
                  check("pop_data", 32'(out_data), 32'(exp_d));
               end
               if (first_pop < 0) first_pop = cyc;
               last_pop = cyc;
               npops++;
            end
            if (in_valid && ir_exp) begin
               exp_q.push_back(in_data);
               tb_wptr++;
            end
            tb_buf  = tb_buf + tb_pend - pop_n;
            tb_pend = reb ? 1 : 0;
            if (reb) tb_rptr++;
         end
      end
   end

   typedef struct packed {
      logic       rst, iv;
      logic [7:0] d;
      logic       ordy;
      logic       ir, ov;
      logic [7:0] od;
      logic       chk_d;
      logic [9:0] lvl;
      logic       we, rb, af;
   } vec_t;

   localparam int NV = 13;
   vec_t vec [NV];

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic push(input logic [7:0] d);
      int n;
      n = 0;
      in_valid = 1'b1; in_data = d;
      @(negedge clk);
      while (!in_ready && n < 20) begin
         n++;
         @(negedge clk);
      end
      if (!in_ready) check("push_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      in_valid = 1'b0; out_ready = 1'b1;
      while (exp_q.size() != 0 && n < 2000) begin
         @(posedge clk); #1;
         n++;
      end
      check("drain_done", 32'(exp_q.size()), 32'd0);
      @(negedge clk);
      check("drain_level", 32'(level), 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;
      bit acc;
      int nxt, guard;

      //          rst iv d      or  ir ov od     cd lvl  we rb af
      vec[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 10'd0, 1'b0, 1'b0, 1'b0};
      vec[1]  = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 10'd0, 1'b1, 1'b0, 1'b0};
      vec[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 10'd1, 1'b0, 1'b1, 1'b0};
      vec[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 10'd1, 1'b0, 1'b0, 1'b0};
      vec[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b1, 10'd1, 1'b0, 1'b0, 1'b0};
      vec[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0};
      vec[6]  = '{1'b0, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 10'd0, 1'b1, 1'b0, 1'b0};
      vec[7]  = '{1'b0, 1'b1, 8'hC3, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 10'd1, 1'b1, 1'b1, 1'b0};
      vec[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 10'd2, 1'b0, 1'b1, 1'b0};
      vec[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b1, 10'd2, 1'b0, 1'b0, 1'b0};
      vec[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h5A, 1'b1, 10'd2, 1'b0, 1'b0, 1'b0};
      vec[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hC3, 1'b1, 10'd1, 1'b0, 1'b0, 1'b0};
      vec[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0};

      rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      mon_en = 1'b1;

      // Reset state, single word latency, and two-entry buffer fill/shift.
      for (int i = 0; i < NV; i++) begin
         rst = vec[i].rst; in_valid = vec[i].iv; in_data = vec[i].d; out_ready = vec[i].ordy;
         @(negedge clk);
         check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vec[i].ir));
         check($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vec[i].ov));
         if (vec[i].chk_d) check($sformatf("v%0d_out_data", i), 32'(out_data), 32'(vec[i].od));
         check($sformatf("v%0d_level", i), 32'(level), 32'(vec[i].lvl));
         check($sformatf("v%0d_wea", i), 32'(wea), 32'(vec[i].we));
         check($sformatf("v%0d_reb", i), 32'(reb), 32'(vec[i].rb));
         check($sformatf("v%0d_afull", i), 32'(afull), 32'(vec[i].af));
         check($sformatf("v%0d_ties", i), 32'({rea, web, dib}), 32'd0);
         @(posedge clk); #1;
      end

      // Fill to full with the consumer stalled.
      do_reset();
      for (int i = 0; i < 256; i++) push(8'(i));
      push(8'h11);
      push(8'h22);
      in_valid = 1'b1; in_data = 8'hEE; out_ready = 1'b0;
      @(negedge clk);
      check("full_in_ready", 32'(in_ready), 32'd0);
      check("full_level", 32'(level), 32'd258);
      check("full_afull", 32'(afull), 32'd1);
      check("full_no_wea", 32'(wea), 32'd0);
      check("full_head", 32'(out_data), 32'h00);
      @(posedge clk); #1;
      // Pop one word at full: the freed slot is address 2 (0 and 1 were reused by 0x11/0x22).
      out_ready = 1'b1;
      @(negedge clk);
      check("fullpop_no_wea", 32'(wea), 32'd0);
      check("fullpop_reb", 32'(reb), 32'd1);
      check("fullpop_addrb", 32'(addrb), 32'd2);
      @(posedge clk); #1;
      out_ready = 1'b0; in_data = 8'h77;
      @(negedge clk);
      check("refill_in_ready", 32'(in_ready), 32'd1);
      check("refill_wea", 32'(wea), 32'd1);
      check("refill_addra", 32'(addra), 32'd2);
      @(posedge clk); #1;
      in_valid = 1'b0;
      drain();

      // Wrap-around streaming with the consumer always ready.
      do_reset();
      out_ready = 1'b1;
      first_pop = -1; last_pop = -1; npops = 0;
      for (int i = 0; i < 1000; i++) push(8'(i));
      drain();
      check("stream_pops", 32'(npops), 32'd1000);
      check("stream_gapless", 32'(last_pop - first_pop), 32'd999);

      // Random backpressure under continuous push.
      do_reset();
      max_level = 0; nxt = 0; guard = 0;
      while (nxt < 600 && guard < 5000) begin
         in_valid = 1'b1; in_data = 8'(nxt * 7 + 3); out_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         acc = in_ready;
         @(posedge clk); #1;
         if (acc) nxt++;
         guard++;
      end
      check("bp_pushed", 32'(nxt), 32'd600);
      drain();
      check("bp_level_max", 32'(max_level <= 258), 32'd1);

      // Reset while a read is in flight.
      do_reset();
      out_ready = 1'b1;
      push(8'h10); push(8'h11); push(8'h12); push(8'h13);
      found = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (!found) begin
            if (tb_pend != 0) found = 1'b1;
            else begin
               @(posedge clk); #1;
            end
         end
      end
      check("rd_pend_seen", 32'(found), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_level", 32'(level), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_reb", 32'(reb), 32'd0);
      repeat (4) @(posedge clk);
      #1;
      check("rst_no_stale", 32'(out_valid), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
